// File: rtl/reset_sequencer.sv
// reset_sequencer
//   Releases the board's peripheral resets one at a time, in index order,
//   after a start pulse. Consecutive releases are STEP_DELAY ce ticks apart.
//   An optional CSR register reports status and lets software restart or
//   halt the sequence. The register is built only when RST_SEQ_CSR_EN is
//   defined.
//
// Parameters
//   NUM_STEPS  : number of sequenced resets (1..8)
//   STEP_DELAY : ce ticks between consecutive releases (1..255)
//   BASE_ADDR  : CSR address of the status/control register
//
// Ports
//   clk     in   single clock
//   rst     in   asynchronous active-high reset
//   ce      in   one-cycle 32 kHz tick
//   start   in   one-cycle pulse that (re)starts the sequence
//   hold    in   per-reset keep-in-reset mask
//   csr_a   in   CSR address
//   csr_di  in   CSR write data (bit 7 restart, bit 6 halt)
//   csr_we  in   CSR write strobe
//   csr_do  out  CSR read data {busy, done, 3'b000, step}; 8'h00 off-address
//   rst_out out  active-high reset requests, bit k drives peripheral k
//   done    out  high once every step has been released
module reset_sequencer #(
  parameter int         NUM_STEPS  = 6,
  parameter logic [7:0] STEP_DELAY = 8'd32,
  parameter logic [4:0] BASE_ADDR  = 5'h1d
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ce,
  input  logic                 start,
  input  logic [NUM_STEPS-1:0] hold,
  input  logic [4:0]           csr_a,
  input  logic [7:0]           csr_di,
  input  logic                 csr_we,
  output logic [7:0]           csr_do,
  output logic [NUM_STEPS-1:0] rst_out,
  output logic                 done
);

  typedef enum logic [1:0] {
    ASSERT = 2'd0,
    WAIT   = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [2:0] LAST_STEP = 3'(NUM_STEPS - 1);
  localparam logic [7:0] CNT_LAST  = STEP_DELAY - 8'd1;

  state_t               state;
  logic [NUM_STEPS-1:0] seq_mask;
  logic [2:0]           step;
  logic [7:0]           cnt;
  logic                 restart;
  logic                 halt;

`ifdef RST_SEQ_CSR_EN
  logic csr_sel;
  logic csr_unused;

  assign csr_sel    = (csr_a == BASE_ADDR);
  // start and a CSR restart in the same cycle merge into one restart.
  assign restart    = start | (csr_sel & csr_we & csr_di[7]);
  assign halt       = csr_sel & csr_we & csr_di[6];
  assign csr_do     = csr_sel ? {(state == WAIT), done, 3'b000, step} : 8'h00;
  assign csr_unused = ^csr_di[5:0];
`else
  logic csr_unused;

  assign restart    = start;
  assign halt       = 1'b0;
  assign csr_do     = 8'h00;
  assign csr_unused = ^{csr_a, csr_di, csr_we, BASE_ADDR};
`endif

  // hold is combinational so config bits act immediately and never
  // disturb the sequence timing.
  assign rst_out = seq_mask | hold;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ASSERT;
      seq_mask <= '1;
      step     <= 3'd0;
      cnt      <= 8'd0;
      done     <= 1'b0;
    end else if (halt || restart) begin
      // Halt wins over restart; either one swallows a coincident ce.
      state    <= halt ? ASSERT : WAIT;
      seq_mask <= '1;
      step     <= 3'd0;
      cnt      <= 8'd0;
      done     <= 1'b0;
    end else begin
      case (state)
        WAIT: begin
          if (ce) begin
            if (cnt == CNT_LAST) begin
              cnt <= 8'd0;
              // Releases go strictly in index order, so the still-asserted
              // bits are always the top ones: clearing bit 'step' is a shift.
              seq_mask <= seq_mask << 1;
              if (step == LAST_STEP) begin
                state <= DONE;
                done  <= 1'b1;
              end else begin
                step <= step + 3'd1;
              end
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer
//   Drives two sequencers from one stimulus stream: the default build
//   (6 steps, 32 ticks apart) and a minimal one (1 step, 1 tick apart).
//   A reference model based on counted ce ticks predicts every cycle's
//   outputs; predictions are queued and a monitor compares them against
//   the DUTs on the falling clock edge.
module tb_reset_sequencer;

  localparam logic [4:0] BASE = 5'h1d;
`ifdef RST_SEQ_CSR_EN
  localparam bit CSR_EN = 1'b1;
`else
  localparam bit CSR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ce = 1'b0;
  logic       start = 1'b0;
  logic       csr_we = 1'b0;
  logic [4:0] csr_a = BASE;
  logic [7:0] csr_di = 8'h00;
  logic [5:0] hold0 = 6'd0;
  logic [0:0] hold1 = 1'b0;

  logic [7:0] csr_do0, csr_do1;
  logic [5:0] rst_out0;
  logic [0:0] rst_out1;
  logic       done0, done1;

  reset_sequencer dut0 (
    .clk(clk), .rst(rst), .ce(ce), .start(start), .hold(hold0),
    .csr_a(csr_a), .csr_di(csr_di), .csr_we(csr_we),
    .csr_do(csr_do0), .rst_out(rst_out0), .done(done0)
  );

  reset_sequencer #(.NUM_STEPS(1), .STEP_DELAY(8'd1), .BASE_ADDR(5'h1d)) dut1 (
    .clk(clk), .rst(rst), .ce(ce), .start(start), .hold(hold1),
    .csr_a(csr_a), .csr_di(csr_di), .csr_we(csr_we),
    .csr_do(csr_do1), .rst_out(rst_out1), .done(done1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  // Reference model: phase (0 idle/asserted, 1 running, 2 finished) and the
  // number of ce ticks counted since the last start.
  int st[2];
  int cnt[2];

  typedef struct {
    logic [7:0] ro0;
    logic [7:0] ro1;
    logic [7:0] cs0;
    logic [7:0] cs1;
    logic       d0;
    logic       d1;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  function automatic int n_of(input int d);
    return (d == 0) ? 6 : 1;
  endfunction

  function automatic int sd_of(input int d);
    return (d == 0) ? 32 : 1;
  endfunction

  // Bit k is released once (k+1)*delay ticks have been counted.
  function automatic logic [7:0] m_mask(input int d, input logic [7:0] h);
    logic [7:0] m;
    m = 8'h00;
    for (int k = 0; k < n_of(d); k++)
      if (st[d] == 0 || (st[d] == 1 && cnt[d] < (k + 1) * sd_of(d)))
        m[k] = 1'b1;
    return m | h;
  endfunction

  function automatic logic [7:0] m_csr(input int d, input logic [4:0] a);
    int stp;
    if (!CSR_EN || a != BASE) return 8'h00;
    if (st[d] == 0)      stp = 0;
    else if (st[d] == 1) stp = cnt[d] / sd_of(d);
    else                 stp = n_of(d) - 1;
    return {(st[d] == 1), (st[d] == 2), 3'b000, 3'(stp)};
  endfunction

  function automatic void m_step(input logic r, input logic c, input logic s,
                                 input logic [4:0] a, input logic [7:0] di,
                                 input logic we);
    logic sel;
    sel = CSR_EN && we && (a == BASE);
    for (int d = 0; d < 2; d++) begin
      if (r) begin
        st[d] = 0; cnt[d] = 0;
      end else if (sel && di[6]) begin
        st[d] = 0; cnt[d] = 0;
      end else if (s || (sel && di[7])) begin
        st[d] = 1; cnt[d] = 0;
      end else if (st[d] == 1 && c) begin
        cnt[d]++;
        if (cnt[d] == n_of(d) * sd_of(d)) st[d] = 2;
      end
    end
  endfunction

  function automatic void chk(input string nm, input int cyc,
                              input logic [7:0] act, input logic [7:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%h expected=%h", nm, cyc, act, expv);
    end
  endfunction

  function automatic void push_exp();
    exp_t e;
    e.ro0 = m_mask(0, {2'b00, hold0});
    e.ro1 = m_mask(1, {7'd0, hold1});
    e.cs0 = m_csr(0, csr_a);
    e.cs1 = m_csr(1, csr_a);
    e.d0  = (st[0] == 2);
    e.d1  = (st[1] == 2);
    e.cyc = cycle;
    exp_q.push_back(e);
  endfunction

  // Monitor: compares whatever the DUTs present against the queued prediction.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("rst_out0", mon_e.cyc, {2'b00, rst_out0}, mon_e.ro0);
      chk("done0",    mon_e.cyc, {7'd0, done0},     {7'd0, mon_e.d0});
      chk("csr_do0",  mon_e.cyc, csr_do0,           mon_e.cs0);
      chk("rst_out1", mon_e.cyc, {7'd0, rst_out1},  mon_e.ro1);
      chk("done1",    mon_e.cyc, {7'd0, done1},     {7'd0, mon_e.d1});
      chk("csr_do1",  mon_e.cyc, csr_do1,           mon_e.cs1);
    end
  end

  // Called one time unit after a rising edge.
  task automatic tick(input logic c, input logic s, input logic [4:0] a,
                      input logic [7:0] di, input logic we);
    ce = c; start = s; csr_a = a; csr_di = di; csr_we = we;
    push_exp();
    @(posedge clk);
    m_step(rst, c, s, a, di, we);
    cycle++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, BASE, 8'h00, 1'b0);
  endtask

  task automatic run_ce(input int nce, input int period);
    for (int i = 0; i < nce * period; i++)
      tick((i % period) == period - 1, 1'b0, BASE, 8'h00, 1'b0);
  endtask

  // Reset asserted between clock edges; outputs must follow at once.
  task automatic async_reset();
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_out0", cycle, {2'b00, rst_out0}, 8'h3f);
    chk("async_done0",    cycle, {7'd0, done0},     8'h00);
    chk("async_rst_out1", cycle, {7'd0, rst_out1},  8'h01);
    chk("async_done1",    cycle, {7'd0, done1},     8'h00);
    m_step(1'b1, 1'b0, 1'b0, BASE, 8'h00, 1'b0);
    ce = 1'b0; start = 1'b0; csr_we = 1'b0;
    push_exp();
    @(posedge clk);
    cycle++;
    #1;
    rst = 1'b0;
  endtask

  initial begin
    st[0] = 0; st[1] = 0; cnt[0] = 0; cnt[1] = 0;
    @(posedge clk);
    #1;
    repeat (3) tick(1'b0, 1'b0, BASE, 8'h00, 1'b0);
    rst = 1'b0;
    idle(2);

    // Default full run, ce every 4 clocks.
    tick(1'b0, 1'b1, BASE, 8'h00, 1'b0);
    run_ce(200, 4);

    // Full run with bit 2 held.
    hold0 = 6'b000100;
    tick(1'b0, 1'b1, BASE, 8'h00, 1'b0);
    run_ce(200, 4);
    hold0 = 6'b000000;

    // Restart after two releases.
    tick(1'b0, 1'b1, BASE, 8'h00, 1'b0);
    run_ce(80, 4);
    tick(1'b0, 1'b1, BASE, 8'h00, 1'b0);
    run_ce(40, 4);

    // Asynchronous reset mid-run.
    tick(1'b0, 1'b1, BASE, 8'h00, 1'b0);
    run_ce(50, 3);
    async_reset();
    idle(3);

    // ce coincident with start is ignored; the next ce finishes the short one.
    tick(1'b1, 1'b1, BASE, 8'h00, 1'b0);
    idle(2);
    tick(1'b1, 1'b0, BASE, 8'h00, 1'b0);
    idle(2);

`ifdef RST_SEQ_CSR_EN
    tick(1'b0, 1'b1, BASE, 8'h00, 1'b0);
    run_ce(40, 4);
    tick(1'b0, 1'b0, BASE, 8'hC0, 1'b1);   // halt + restart: halt wins
    idle(3);
    tick(1'b0, 1'b0, BASE, 8'h80, 1'b1);   // software restart
    run_ce(100, 2);
    tick(1'b1, 1'b1, BASE, 8'h80, 1'b1);   // start + CSR restart + ce
    run_ce(200, 2);
    idle(2);                               // reads 8'h45 at BASE
    tick(1'b0, 1'b0, 5'h03, 8'h00, 1'b0);  // other address reads zero
    tick(1'b0, 1'b0, 5'h1c, 8'h80, 1'b1);  // write elsewhere does nothing
    idle(2);
    tick(1'b0, 1'b1, BASE, 8'h40, 1'b1);   // start + halt: halt wins
    idle(3);
`endif

    // Randomized traffic.
    for (int i = 0; i < 5000; i++) begin
      logic c, s, we;
      logic [4:0] a;
      logic [7:0] di;
      c  = ($urandom_range(0, 1) == 1);
      s  = ($urandom_range(0, 799) == 0);
      we = ($urandom_range(0, 499) == 0);
      a  = ($urandom_range(0, 2) == 0) ? 5'($urandom_range(0, 31)) : BASE;
      di = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 299) == 0) begin
        hold0 = 6'($urandom_range(0, 63));
        hold1 = 1'($urandom_range(0, 1));
      end
      tick(c, s, a, di, we);
    end
    idle(2);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Sequences release of the board's peripheral resets after the CPLD leaves power-on reset. All managed resets are released one at a time, in index order, spaced by a programmable number of 32 kHz ticks, so that PHY, hub, bridge and PCIe devices do not leave reset simultaneously. It sits beside the config controller: the config-read-done pulse starts it, and its outputs feed the existing reset pin drivers. An optional CSR register on the shared I2C-slave CSR bus reports status and lets software restart or halt the sequence.

## Interface

Parameters:
- NUM_STEPS, 6: number of sequenced resets; legal range 1..8.
- STEP_DELAY, 8'd32: ce ticks between consecutive releases; legal range 1..255 (0 illegal).
- BASE_ADDR, 5'h1d: CSR address of the status/control register.

Ports:
- clk, input, 1: single clock; the only clock in the block.
- rst, input, 1: asynchronous, active-high reset.
- ce, input, 1: one-cycle tick, 32 kHz.
- start, input, 1: one-cycle pulse that (re)starts the sequence.
- hold, input, NUM_STEPS: per-reset keep-in-reset mask from config bits.
- csr_a, input, 5: CSR address.
- csr_di, input, 8: CSR write data.
- csr_we, input, 1: CSR write strobe, one cycle.
- csr_do, output, 8: CSR read data; 8'h00 when csr_a != BASE_ADDR.
- rst_out, output, NUM_STEPS: active-high reset requests; bit k drives peripheral k.
- done, output, 1: high once all steps have been released.

## Operation

- Internal state: seq_mask[NUM_STEPS-1:0], step index (3 bits), cnt (8 bits), FSM state.
- rst_out = seq_mask | hold. This is combinational from hold. A held bit stays asserted, and sequence timing is unaffected by hold.
- FSM states and transitions:
  - ASSERT: entered on rst. seq_mask all ones, step 0, cnt 0, done 0. Goes to WAIT on start or CSR restart.
  - WAIT: on each ce, cnt increments. When ce arrives with cnt == STEP_DELAY-1:
    - clear seq_mask[step] and set cnt to 0;
    - if step == NUM_STEPS-1, go to DONE; otherwise step increments.
  - DONE: done 1, seq_mask all zero, step holds NUM_STEPS-1.
- Restart, by start or CSR bit 7, in any state:
  - seq_mask set to all ones, step 0, cnt 0, done 0, next state WAIT.
  - In WAIT, this aborts the run in progress.
- Halt, CSR bit 6: seq_mask set to all ones, step 0, cnt 0, done 0, next state ASSERT.
- Simultaneous events:
  - halt and restart in the same cycle: halt wins;
  - start and CSR restart in the same cycle: a single restart;
  - restart and ce in the same cycle: the ce is ignored.
- Async rst during any state returns the block to ASSERT immediately, with all resets asserted.

## Timing

- Reset values: rst_out all ones, done 0, csr_do 8'h00, FSM in ASSERT.
- start sampled at edge N puts the FSM in WAIT after edge N.
- Only ce pulses sampled at edges after N are counted.
- Release timing:
  - rst_out[k] falls after the edge sampling the ((k+1)·STEP_DELAY)-th counted ce;
  - done rises on the same edge as the last bit releases.
- Full sequence length is NUM_STEPS·STEP_DELAY ce ticks; defaults give 192 ticks, about 5.86 ms.
- CSR writes take effect at the edge sampling csr_we. Read data is combinational from the current state.
- CSR read format: {busy, done, 3'b000, step[2:0]}.
  - busy = FSM in WAIT.
  - In ASSERT the value is 8'h00. In DONE with defaults it is 8'h45.

## Configuration

- RST_SEQ_CSR_EN defined: the CSR register is present as described above.
- RST_SEQ_CSR_EN undefined:
  - csr_do is tied to 8'h00, and csr_a, csr_di and csr_we are ignored;
  - restart comes only from start, and halt does not exist.

## Test plan

- Defaults. Assert rst, release it, pulse start, drive ce every 4 clk. Expect rst_out to go 6'b111111 → 111110 after 32 ce → 111100 after 64 ce, and so on; 000000 plus done = 1 after 192 ce.
- hold = 6'b000100 through a full run. Expect bit 2 to stay 1 throughout, other bits to release on schedule, and done = 1 at ce 192.
- start pulsed at ce 80 (2 bits released). Expect rst_out to return to 111111 the next cycle and bit 0 to release 32 ce later.
- CSR (RST_SEQ_CSR_EN defined):
  - write 8'hC0 mid-run: expect ASSERT and a read of 8'h00;
  - write 8'h80: expect the sequence to restart;
  - read when done: expect 8'h45;
  - read at another address: expect 8'h00.
- Async rst asserted mid-run, between clk edges. Expect rst_out = 111111 and done = 0 without waiting for a clk edge.
- STEP_DELAY = 1, NUM_STEPS = 1. Expect rst_out to clear and done to rise on the first ce after start; a ce coincident with start is ignored.
